// File: rtl/signal_limit_pkg.sv
// Shared mode encodings and wide signed helpers for the limit/slew channel datapath.
package signal_limit_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BYPASS = 2'd0;
  localparam mode_t MODE_CLAMP  = 2'd1;
  localparam mode_t MODE_SLEW   = 2'd2;
  localparam mode_t MODE_HOLD   = 2'd3;

  // Wide enough that sign-extended differences of any practical DATA_W never overflow.
  localparam int WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic wide_t smin(input wide_t a, input wide_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic wide_t sat(input wide_t v, input int w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    return smin(smax(v, lo), hi);
  endfunction

endpackage

// File: rtl/signal_limit_ch.sv
// One channel: stage-1 window clamp, stage-2 slew limiter / hold, sticky flags and clip counter.
module signal_limit_ch
  import signal_limit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s1_en,
  input  logic                     s2_en,
  input  logic                     clr_stat,
  input  mode_t                    mode,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] limit_upper,
  input  logic signed [DATA_W-1:0] limit_lower,
  input  logic        [DATA_W-1:0] slew_step,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     clip_flag,
  output logic                     slew_flag,
  output logic                     cfg_err,
  output logic        [CNT_W-1:0]  clip_cnt
);

  logic signed [DATA_W-1:0] c_q;
  mode_t                    mode_q;
  logic        [DATA_W-1:0] step_q;
  logic                     clip_q;

  wide_t in_x, up_x, lo_x, c_x, cq_x, last_x, step_x, d_x, y_x;
  logic  bad, clip_c, slewed;

  assign in_x   = wide_t'(in_data);
  assign up_x   = wide_t'(limit_upper);
  assign lo_x   = wide_t'(limit_lower);
  assign cq_x   = wide_t'(c_q);
  assign last_x = wide_t'(out_data);
  assign step_x = wide_t'(step_q);
  assign bad    = lo_x > up_x;

  always_comb begin
    c_x    = in_x;
    clip_c = 1'b0;
    if (mode != MODE_BYPASS) begin
      // An inverted window pins to the lower bound and is counted as a clip.
      if (bad) begin
        c_x    = lo_x;
        clip_c = 1'b1;
      end else begin
        c_x    = smin(smax(in_x, lo_x), up_x);
        clip_c = (in_x > up_x) || (in_x < lo_x);
      end
    end
  end

  always_comb begin
    d_x    = cq_x - last_x;
    y_x    = cq_x;
    slewed = 1'b0;
    if (mode_q == MODE_HOLD) begin
      y_x = last_x;
    end else if (mode_q == MODE_SLEW && step_q != '0) begin
      if (d_x > step_x) begin
        y_x    = last_x + step_x;
        slewed = 1'b1;
      end else if (d_x < -step_x) begin
        y_x    = last_x - step_x;
        slewed = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      mode_q  <= MODE_BYPASS;
      step_q  <= '0;
      clip_q  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= bad;
      if (s1_en) begin
        c_q    <= DATA_W'(c_x);
        mode_q <= mode;
        step_q <= slew_step;
        clip_q <= clip_c;
      end
    end
  end

  // out_data doubles as the slew reference, so it tracks whatever was actually emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      clip_flag <= 1'b0;
      slew_flag <= 1'b0;
      clip_cnt  <= '0;
    end else begin
      if (s2_en) out_data <= DATA_W'(sat(y_x, DATA_W));
      if (clr_stat) begin
        clip_flag <= 1'b0;
        slew_flag <= 1'b0;
        clip_cnt  <= '0;
      end else if (s2_en) begin
        if (clip_q) begin
          clip_flag <= 1'b1;
          if (clip_cnt != '1) clip_cnt <= clip_cnt + 1'b1;
        end
        if (slewed) slew_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/signal_limit_slew.sv
// Multi-channel clamp + slew limiter: shared 2-stage valid pipeline, per-channel datapath slices.
module signal_limit_slew
  import signal_limit_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH*DATA_W-1:0]   limit_upper,
  input  logic [N_CH*DATA_W-1:0]   limit_lower,
  input  logic [N_CH*DATA_W-1:0]   slew_step,
  input  logic                     clr_stat,
  output logic                     out_valid,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [N_CH-1:0]          clip_flag,
  output logic [N_CH-1:0]          slew_flag,
  output logic [N_CH-1:0]          cfg_err,
  output logic [N_CH*CNT_W-1:0]    clip_cnt
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
  end

  assign out_valid = vld_pipe[STAGES-1];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    signal_limit_ch #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .s1_en      (in_valid),
      .s2_en      (vld_pipe[0]),
      .clr_stat   (clr_stat),
      .mode       (mode_t'(mode)),
      .in_data    (in_data[k*DATA_W +: DATA_W]),
      .limit_upper(limit_upper[k*DATA_W +: DATA_W]),
      .limit_lower(limit_lower[k*DATA_W +: DATA_W]),
      .slew_step  (slew_step[k*DATA_W +: DATA_W]),
      .out_data   (out_data[k*DATA_W +: DATA_W]),
      .clip_flag  (clip_flag[k]),
      .slew_flag  (slew_flag[k]),
      .cfg_err    (cfg_err[k]),
      .clip_cnt   (clip_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_signal_limit_slew.sv
// Directed bench for signal_limit_slew: two channels, 16-bit samples, 4-bit clip counters.
module tb_signal_limit_slew;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] limit_upper;
  logic [31:0] limit_lower;
  logic [31:0] slew_step;
  logic        clr_stat;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  clip_flag;
  logic [1:0]  slew_flag;
  logic [1:0]  cfg_err;
  logic [7:0]  clip_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] sin0 [24];
  logic [15:0] sin1 [24];
  logic [15:0] se0  [24];
  logic [15:0] se1  [24];
  logic [1:0]  smd  [24];

  signal_limit_slew #(.N_CH(2), .DATA_W(16), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .limit_upper(limit_upper),
    .limit_lower(limit_lower),
    .slew_step  (slew_step),
    .clr_stat   (clr_stat),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .clip_flag  (clip_flag),
    .slew_flag  (slew_flag),
    .cfg_err    (cfg_err),
    .clip_cnt   (clip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lim(input int u0, input int l0, input int u1, input int l1);
    limit_upper = {16'(u1), 16'(u0)};
    limit_lower = {16'(l1), 16'(l0)};
  endtask

  task automatic put(input int j, input int md, input int a0, input int e0, input int a1, input int e1);
    smd[j]  = 2'(md);
    sin0[j] = 16'(a0);
    se0[j]  = 16'(e0);
    sin1[j] = 16'(a1);
    se1[j]  = 16'(e1);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_stat = 1'b1;
    @(negedge clk); clr_stat = 1'b0;
  endtask

  // Drives n back-to-back samples and checks each output exactly two cycles later.
  task automatic stream(input int n, input string tag);
    for (int j = 0; j < n + 2; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_ch0"}, 32'(out_data[15:0]), 32'(se0[j-2]));
        chk({tag, "_ch1"}, 32'(out_data[31:16]), 32'(se1[j-2]));
      end else begin
        chk({tag, "_lat"}, 32'(out_valid), 32'd0);
      end
      if (j < n) begin
        in_valid = 1'b1;
        in_data  = {sin1[j], sin0[j]};
        mode     = smd[j];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0; clr_stat = 1'b0;
    slew_step = '0;
    set_lim(1000, -1000, 32767, -32768);
    repeat (3) @(negedge clk);
    chk("rst_vld",  32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_clip", 32'(clip_flag), 32'd0);
    chk("rst_slew", 32'(slew_flag), 32'd0);
    chk("rst_cfg",  32'(cfg_err), 32'd0);
    chk("rst_cnt",  32'(clip_cnt), 32'd0);
    rst = 1'b0;

    // clamp; ch1 extremes pass through its full-range window
    put(0, 1, 1500, 1000, 32767, 32767);
    put(1, 1, -32768, -1000, -32768, -32768);
    put(2, 1, 1000, 1000, 0, 0);
    put(3, 1, -5, -5, -1, -1);
    stream(4, "clamp");
    chk("clamp_cnt",  32'(clip_cnt), 32'h02);
    chk("clamp_flag", 32'(clip_flag), 32'd1);
    @(negedge clk);
    chk("clamp_hold", out_data, {16'hFFFF, 16'hFFFB});
    pulse_clr();
    chk("clr_cnt",  32'(clip_cnt), 32'd0);
    chk("clr_flag", 32'(clip_flag), 32'd0);

    // slew from reset, then reverse to negative full scale
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_lim(32767, -32767, 32767, -32768);
    slew_step = {16'd100, 16'd100};
    for (int i = 0; i < 6; i++) put(i, 2, 500, (i < 5) ? 100 * (i + 1) : 500, -32768, -100 * (i + 1));
    stream(6, "slew_up");
    chk("slew_flag", 32'(slew_flag), 32'd3);
    chk("slew_noclip", 32'(clip_flag), 32'd0);
    for (int i = 0; i < 6; i++) put(i, 2, -32768, 400 - 100 * i, 32767, -500 + 100 * i);
    stream(6, "slew_dn");
    chk("slew_dn_cnt", 32'(clip_cnt), 32'h06);

    // inverted window on ch0: clamp mode pins to lower, bypass passes through
    pulse_clr();
    set_lim(100, 200, 32767, -32768);
    @(negedge clk);
    chk("cfg_live", 32'(cfg_err), 32'd1);
    put(0, 1, 150, 200, 7, 7);
    put(1, 0, 150, 150, -7, -7);
    stream(2, "cfg");
    chk("cfg_cnt", 32'(clip_cnt), 32'h01);
    chk("cfg_err", 32'(cfg_err), 32'd1);

    // counter saturation
    set_lim(1000, -1000, 32767, -32768);
    pulse_clr();
    for (int i = 0; i < 20; i++) put(i, 1, 2000, 1000, 0, 0);
    stream(20, "sat");
    chk("sat_cnt",  32'(clip_cnt), 32'h0F);
    chk("sat_flag", 32'(clip_flag), 32'd1);

    // clear on the same cycle the clip is recorded
    @(negedge clk); in_valid = 1'b1; in_data = {16'd0, 16'd2000}; mode = 2'd1;
    @(negedge clk); in_valid = 1'b0; clr_stat = 1'b1;
    @(negedge clk); clr_stat = 1'b0;
    chk("coin_vld",  32'(out_valid), 32'd1);
    chk("coin_data", 32'(out_data[15:0]), 32'd1000);
    @(negedge clk);
    chk("coin_cnt",  32'(clip_cnt), 32'd0);
    chk("coin_flag", 32'(clip_flag), 32'd0);

    // reset with samples in flight
    slew_step = {16'd100, 16'd100};
    @(negedge clk); in_valid = 1'b1; in_data = {16'd500, 16'd2000}; mode = 2'd2;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    chk("mid_vld0", 32'(out_valid), 32'd0);
    chk("mid_data", out_data, 32'd0);
    @(negedge clk);
    chk("mid_vld1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("mid_vld2", 32'(out_valid), 32'd0);
    put(0, 2, 500, 100, 500, 100);
    stream(1, "mid_ramp");

    // hold freezes per channel; ch0 limits leave ch1 extremes alone
    pulse_clr();
    put(0, 1, 50, 50, 32767, 32767);
    put(1, 1, -70, -70, -32768, -32768);
    put(2, 3, 999, -70, 0, -32768);
    put(3, 3, 999, -70, 0, -32768);
    stream(4, "hold");
    chk("hold_clip", 32'(clip_flag), 32'd0);

    // full-scale jump exactly equal to step is not limited; step 0 disables slew
    slew_step = {16'hFFFF, 16'h0000};
    put(0, 2, 5, 5, 32767, 32767);
    stream(1, "wide");
    chk("wide_slew", 32'(slew_flag), 32'd0);
    slew_step = {16'd1, 16'd0};
    put(0, 2, 5, 5, -32768, 32766);
    stream(1, "step1");
    chk("step1_slew", 32'(slew_flag), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signal_limit_slew.md
Name: signal_limit_slew

Overview:
- Multi-channel successor to the single-channel DAC clamp.
- Per channel: signed window clamp, then an optional slew-rate limiter, plus clip statistics.
- Sits between the waveform generator / sequence output and the DAC formatter, one instance per DAC group.
- Streaming input with a valid strobe, fixed 2-cycle latency, no backpressure.

Parameters:
- N_CH, 2, number of channels.
- DATA_W, 16, signed sample width.
- CNT_W, 16, width of the per-channel saturating clip counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  0 = bypass, 1 = clamp, 2 = clamp+slew, 3 = hold last output.
- in_valid  in  1  sample strobe, common to all channels.
- in_data  in  N_CH*DATA_W  signed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- limit_upper  in  N_CH*DATA_W  signed upper bound per channel.
- limit_lower  in  N_CH*DATA_W  signed lower bound per channel.
- slew_step  in  N_CH*DATA_W  unsigned maximum |delta| per valid sample; 0 disables slew.
- clr_stat  in  1  one-cycle pulse; clears flags and counters.
- out_valid  out  1  output strobe.
- out_data  out  N_CH*DATA_W  limited samples.
- clip_flag  out  N_CH  sticky: a clamp occurred since the last clear.
- slew_flag  out  N_CH  sticky: the slew limiter engaged since the last clear.
- cfg_err  out  N_CH  live (not sticky): limit_lower > limit_upper, registered.
- clip_cnt  out  N_CH*CNT_W  saturating count of clamped samples.

Behaviour:
- Reset:
  - out_valid, out_data, all flags, cfg_err and clip_cnt go to 0.
  - Pipeline valid bits clear; slew state (last output) = 0.
  - An in-flight sample is dropped and never appears.
- Comparisons are signed throughout. Limits, mode and slew_step are sampled in stage 1, on the same cycle as the in_valid sample.
- Stage 1 (in_valid high), clamp:
  - mode 0: c = in.
  - Otherwise, when limit_lower <= limit_upper: c = upper if in > upper, lower if in < lower, else in.
  - in equal to a limit is not a clip.
  - When limit_lower > limit_upper: c = limit_lower, cfg_err[k] = 1, and the sample counts as a clip.
- Stage 2, slew:
  - mode 2 with step != 0:
    - d = c - last, computed at DATA_W+1 bits signed.
    - d > step gives last + step; d < -step gives last - step; otherwise c.
    - No overflow is possible because the result stays between last and c.
  - mode 3: output = last; the input is ignored but in_valid still propagates.
  - All other modes: output = c.
  - last is updated with every emitted output, in all modes, so slew resumes from the true DAC value after a mode change.
- Latency:
  - out_valid = in_valid delayed by exactly 2 cycles.
  - out_data holds its value between strobes.
  - Back-to-back valids are accepted every cycle.
- Statistics:
  - A clip sets clip_flag[k] and increments clip_cnt[k]. The counter saturates at 2^CNT_W-1 and does not wrap.
  - slew_flag[k] sets when stage 2 modifies the value.
  - clr_stat coinciding with an event: clear wins and the event is discarded.
  - Statistics update on the stage-2 cycle, registered, aligned with out_valid.
- Mode change mid-stream takes effect on the next in_valid sample; samples already in flight keep their stage-1 mode.
- in_valid low leaves all state unchanged.

Decomposition:
- Shared package `signal_limit_pkg`:
  - Mode encodings MODE_BYPASS / MODE_CLAMP / MODE_SLEW / MODE_HOLD.
  - A function for DATA_W-bit signed saturation and min/max helpers.
- Sub-module `signal_limit_ch`, one per channel via generate:
  - Contains the clamp, the slew register, the flags and the counter.
  - The top level handles the valid pipeline and bus slicing only.

Test Plan:
- Clamp, mode 1, upper = 1000, lower = -1000, inputs 1500, -32768, 1000, -5:
  - Outputs 1000, -1000, 1000, -5, each 2 cycles after its valid.
  - clip_cnt = 2, clip_flag = 1.
- Slew, mode 2, step = 100, limits +/-32767, from reset, input 500 held for 6 samples:
  - Outputs 100, 200, 300, 400, 500, 500; slew_flag = 1.
  - Repeat with a step to -32768: output ramps down at -100 per sample, with no wrap.
- Config error, lower = 200, upper = 100, input 150:
  - Output 200, cfg_err = 1, clip_cnt increments.
  - Bypass mode with the same limits: output 150, with cfg_err still reported.
- Statistics boundary, CNT_W = 4:
  - Drive 20 clipping samples: clip_cnt stops at 15.
  - clr_stat on the same cycle as a clip: counter = 0 and flag = 0 afterwards.
- Reset mid-stream, rst pulsed with 2 samples in flight:
  - No out_valid appears from those samples.
  - The next slew-mode sample starts its ramp from 0.
- Hold / multi-channel, N_CH = 2, channel 1 sign extremes, switch to mode 3 mid-stream:
  - Output freezes at the last value per channel.
  - Channels are independent: channel 0 limits do not affect channel 1.
